// File: rtl/usb_tx_sched.sv
// rtl/usb_tx_sched.sv - USB TX scheduler: handshake/data arbitration, byte streaming, gap and watchdog
module usb_tx_sched #(
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MAX_SIZE       = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hs_req,
    input  logic       hs_type,
    input  logic       data_req,
    input  logic [6:0] data_size,
    input  logic [7:0] data_byte,
    output logic       data_pop,
    output logic       hs_ack,
    output logic       data_ack,
    output logic       data_abort,
    output logic [1:0] tx_packet,
    output logic [6:0] tx_packet_data_size,
    output logic [7:0] tx_packet_data,
    input  logic       get_tx_packet,
    input  logic       tx_done,
    output logic       busy,
    output logic [2:0] err_flags,
    input  logic       err_clr
);

    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [6:0]       SIZE_MAX  = 7'(MAX_SIZE);

    localparam logic [1:0] PKT_NONE = 2'b00;
    localparam logic [1:0] PKT_DATA = 2'b01;
    localparam logic [1:0] PKT_ACK  = 2'b10;
    localparam logic [1:0] PKT_NAK  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_ACTIVE,
        S_GAP
    } state_t;

    state_t           state;
    logic [1:0]       kind;
    logic [6:0]       byte_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic       is_data;
    logic       active;
    logic       pull;
    logic       overrun;
    logic       underrun;
    logic       oversize;
    logic       timeout;
    logic [6:0] byte_cnt_next;
    logic [2:0] err_set;

    // tx_packet_data_size doubles as the latched packet size for byte accounting
    always_comb begin
        is_data        = (kind == PKT_DATA);
        active         = (state == S_ACTIVE);
        pull           = active && get_tx_packet;
        data_pop       = pull && is_data && (byte_cnt < tx_packet_data_size);
        overrun        = pull && !data_pop;
        byte_cnt_next  = byte_cnt + 7'(data_pop);
        underrun       = active && tx_done && is_data && (byte_cnt_next != tx_packet_data_size);
        oversize       = (state == S_IDLE) && !hs_req && data_req && (data_size > SIZE_MAX);
        timeout        = active && !tx_done && (wd_cnt == WD_LAST);
        err_set        = {timeout, underrun | oversize, overrun};
        tx_packet_data = (active && is_data) ? data_byte : 8'h00;
        busy           = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= S_IDLE;
            kind                <= PKT_NONE;
            byte_cnt            <= '0;
            wd_cnt              <= '0;
            gap_cnt             <= '0;
            hs_ack              <= 1'b0;
            data_ack            <= 1'b0;
            data_abort          <= 1'b0;
            tx_packet           <= PKT_NONE;
            tx_packet_data_size <= '0;
            err_flags           <= '0;
        end else begin
            // a fresh error in the clearing cycle survives the clear
            err_flags  <= (err_clr ? 3'b000 : err_flags) | err_set;
            hs_ack     <= 1'b0;
            data_ack   <= 1'b0;
            data_abort <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (hs_req) begin
                        kind                <= hs_type ? PKT_NAK : PKT_ACK;
                        tx_packet           <= hs_type ? PKT_NAK : PKT_ACK;
                        tx_packet_data_size <= '0;
                        state               <= S_LAUNCH;
                    end else if (data_req) begin
                        kind                <= PKT_DATA;
                        tx_packet           <= PKT_DATA;
                        tx_packet_data_size <= (data_size > SIZE_MAX) ? SIZE_MAX : data_size;
                        state               <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    tx_packet <= PKT_NONE;
                    byte_cnt  <= '0;
                    wd_cnt    <= '0;
                    state     <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    byte_cnt <= byte_cnt_next;
                    wd_cnt   <= wd_cnt + WD_W'(1);
                    if (tx_done) begin
                        data_ack <= is_data;
                        hs_ack   <= !is_data;
                        gap_cnt  <= '0;
                        state    <= S_GAP;
                    end else if (timeout) begin
                        // a stalled handshake is released via hs_ack so the requester is not stuck
                        data_abort <= is_data;
                        hs_ack     <= !is_data;
                        gap_cnt    <= '0;
                        state      <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_sched.sv
// tb/tb_usb_tx_sched.sv - directed bench for usb_tx_sched with GAP_CYCLES=16, TIMEOUT_CYCLES=64
module tb_usb_tx_sched;

    logic       clk;
    logic       rst;
    logic       hs_req;
    logic       hs_type;
    logic       data_req;
    logic [6:0] data_size;
    logic [7:0] data_byte;
    logic       data_pop;
    logic       hs_ack;
    logic       data_ack;
    logic       data_abort;
    logic [1:0] tx_packet;
    logic [6:0] tx_packet_data_size;
    logic [7:0] tx_packet_data;
    logic       get_tx_packet;
    logic       tx_done;
    logic       busy;
    logic [2:0] err_flags;
    logic       err_clr;

    int checks = 0;
    int errors = 0;
    int pop_cnt = 0;
    int hs_ack_cnt = 0;
    int data_ack_cnt = 0;
    int abort_cnt = 0;

    usb_tx_sched #(
        .GAP_CYCLES(16),
        .TIMEOUT_CYCLES(64),
        .MAX_SIZE(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hs_req(hs_req),
        .hs_type(hs_type),
        .data_req(data_req),
        .data_size(data_size),
        .data_byte(data_byte),
        .data_pop(data_pop),
        .hs_ack(hs_ack),
        .data_ack(data_ack),
        .data_abort(data_abort),
        .tx_packet(tx_packet),
        .tx_packet_data_size(tx_packet_data_size),
        .tx_packet_data(tx_packet_data),
        .get_tx_packet(get_tx_packet),
        .tx_done(tx_done),
        .busy(busy),
        .err_flags(err_flags),
        .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pulse counters count high cycles, so a stretched pulse shows up as an extra count
    always @(posedge clk) begin
        if (data_pop)   pop_cnt      <= pop_cnt + 1;
        if (hs_ack)     hs_ack_cnt   <= hs_ack_cnt + 1;
        if (data_ack)   data_ack_cnt <= data_ack_cnt + 1;
        if (data_abort) abort_cnt    <= abort_cnt + 1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (busy && n < 200);
    endtask

    task automatic test_reset();
        repeat (2) cyc();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (tx_packet !== 2'b00) begin errors++; $display("FAIL reset_tx_packet got %b exp 00", tx_packet); end
        checks++; if (tx_packet_data_size !== 7'd0) begin errors++; $display("FAIL reset_size got %0d exp 0", tx_packet_data_size); end
        checks++; if (err_flags !== 3'b000) begin errors++; $display("FAIL reset_err got %b exp 000", err_flags); end
        checks++; if ({hs_ack, data_ack, data_abort, data_pop} !== 4'b0000) begin errors++; $display("FAIL reset_pulses got %b exp 0000", {hs_ack, data_ack, data_abort, data_pop}); end
        hs_req = 1'b1;
        hs_type = 1'b1;
        cyc();
        checks++; if (tx_packet !== 2'b00) begin errors++; $display("FAIL reset_holds_grant got %b exp 00", tx_packet); end
    endtask

    task automatic test_nak();
        int n;
        rst = 1'b0;
        cyc();
        checks++; if (tx_packet !== 2'b11) begin errors++; $display("FAIL nak_launch got %b exp 11", tx_packet); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nak_busy got %b exp 1", busy); end
        cyc();
        checks++; if (tx_packet !== 2'b00) begin errors++; $display("FAIL nak_launch_width got %b exp 00", tx_packet); end
        repeat (29) cyc();
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        checks++; if (hs_ack !== 1'b1) begin errors++; $display("FAIL nak_hs_ack got %b exp 1", hs_ack); end
        hs_req = 1'b0;
        wait_idle(n);
        checks++; if (n !== 16) begin errors++; $display("FAIL nak_gap got %0d exp 16", n); end
        checks++; if (hs_ack_cnt !== 1 || data_ack_cnt !== 0) begin errors++; $display("FAIL nak_ack_counts got %0d/%0d exp 1/0", hs_ack_cnt, data_ack_cnt); end
    endtask

    task automatic test_data_stream();
        logic [7:0] bytes [3];
        int n;
        int pops0;
        bytes[0] = 8'hA1;
        bytes[1] = 8'hB2;
        bytes[2] = 8'hC3;
        pops0 = pop_cnt;
        data_req = 1'b1;
        data_size = 7'd3;
        cyc();
        checks++; if (tx_packet !== 2'b01) begin errors++; $display("FAIL data_launch got %b exp 01", tx_packet); end
        checks++; if (tx_packet_data_size !== 7'd3) begin errors++; $display("FAIL data_size got %0d exp 3", tx_packet_data_size); end
        cyc();
        for (int i = 0; i < 3; i++) begin
            data_byte = bytes[i];
            get_tx_packet = 1'b1;
            #1;
            checks++; if (data_pop !== 1'b1 || tx_packet_data !== bytes[i]) begin errors++; $display("FAIL data_byte%0d got pop=%b %h exp pop=1 %h", i, data_pop, tx_packet_data, bytes[i]); end
            cyc();
            get_tx_packet = 1'b0;
            cyc();
        end
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        checks++; if (data_ack !== 1'b1) begin errors++; $display("FAIL data_ack got %b exp 1", data_ack); end
        data_req = 1'b0;
        checks++; if (err_flags !== 3'b000) begin errors++; $display("FAIL data_err got %b exp 000", err_flags); end
        wait_idle(n);
        checks++; if (pop_cnt - pops0 !== 3) begin errors++; $display("FAIL data_pops got %0d exp 3", pop_cnt - pops0); end
    endtask

    task automatic test_priority();
        int n;
        hs_req = 1'b1;
        hs_type = 1'b0;
        data_req = 1'b1;
        data_size = 7'd1;
        cyc();
        checks++; if (tx_packet !== 2'b10) begin errors++; $display("FAIL prio_first got %b exp 10", tx_packet); end
        cyc();
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        checks++; if (hs_ack !== 1'b1) begin errors++; $display("FAIL prio_hs_ack got %b exp 1", hs_ack); end
        hs_req = 1'b0;
        n = 0;
        do begin
            cyc();
            n++;
        end while (tx_packet !== 2'b01 && n < 100);
        // 16 GAP cycles, then the IDLE grant cycle, then LAUNCH
        checks++; if (n !== 17) begin errors++; $display("FAIL prio_data_launch got %0d exp 17", n); end
        checks++; if (tx_packet_data_size !== 7'd1) begin errors++; $display("FAIL prio_size got %0d exp 1", tx_packet_data_size); end
        cyc();
        data_byte = 8'h5A;
        get_tx_packet = 1'b1;
        #1;
        checks++; if (data_pop !== 1'b1 || tx_packet_data !== 8'h5A) begin errors++; $display("FAIL prio_byte got pop=%b %h exp pop=1 5a", data_pop, tx_packet_data); end
        cyc();
        get_tx_packet = 1'b0;
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        checks++; if (data_ack !== 1'b1) begin errors++; $display("FAIL prio_data_ack got %b exp 1", data_ack); end
        data_req = 1'b0;
        wait_idle(n);
    endtask

    task automatic test_errors();
        int n;
        int pops0;
        pops0 = pop_cnt;
        data_req = 1'b1;
        data_size = 7'd2;
        cyc();
        cyc();
        for (int i = 0; i < 3; i++) begin
            data_byte = 8'(8'h10 + i);
            get_tx_packet = 1'b1;
            #1;
            if (i == 2) begin
                checks++; if (data_pop !== 1'b0) begin errors++; $display("FAIL ovr_no_pop got %b exp 0", data_pop); end
            end
            cyc();
            get_tx_packet = 1'b0;
            cyc();
        end
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        data_req = 1'b0;
        checks++; if (err_flags !== 3'b001) begin errors++; $display("FAIL ovr_err got %b exp 001", err_flags); end
        checks++; if (pop_cnt - pops0 !== 2) begin errors++; $display("FAIL ovr_pops got %0d exp 2", pop_cnt - pops0); end
        wait_idle(n);
        data_req = 1'b1;
        data_size = 7'd4;
        cyc();
        cyc();
        get_tx_packet = 1'b1;
        cyc();
        get_tx_packet = 1'b0;
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        data_req = 1'b0;
        checks++; if (data_ack !== 1'b1 || err_flags !== 3'b011) begin errors++; $display("FAIL udr_err got ack=%b %b exp ack=1 011", data_ack, err_flags); end
        wait_idle(n);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        checks++; if (err_flags !== 3'b000) begin errors++; $display("FAIL err_clr got %b exp 000", err_flags); end
    endtask

    task automatic test_oversize();
        int n;
        data_req = 1'b1;
        data_size = 7'd100;
        cyc();
        checks++; if (tx_packet_data_size !== 7'd64 || err_flags !== 3'b010) begin errors++; $display("FAIL oversize got %0d %b exp 64 010", tx_packet_data_size, err_flags); end
        cyc();
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        data_req = 1'b0;
        wait_idle(n);
    endtask

    task automatic test_clear_vs_set();
        int n;
        hs_req = 1'b1;
        hs_type = 1'b0;
        cyc();
        cyc();
        get_tx_packet = 1'b1;
        err_clr = 1'b1;
        #1;
        checks++; if (data_pop !== 1'b0 || tx_packet_data !== 8'h00) begin errors++; $display("FAIL hs_pull got pop=%b %h exp pop=0 00", data_pop, tx_packet_data); end
        cyc();
        get_tx_packet = 1'b0;
        err_clr = 1'b0;
        checks++; if (err_flags !== 3'b001) begin errors++; $display("FAIL set_wins got %b exp 001", err_flags); end
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        hs_req = 1'b0;
        wait_idle(n);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        int acks0;
        int aborts0;
        acks0 = data_ack_cnt;
        aborts0 = abort_cnt;
        data_req = 1'b1;
        data_size = 7'd2;
        cyc();
        n = 0;
        do begin
            cyc();
            n++;
        end while (data_abort !== 1'b1 && n < 100);
        // 64 ACTIVE cycles, registered abort in the following cycle
        checks++; if (n !== 65) begin errors++; $display("FAIL wd_abort_time got %0d exp 65", n); end
        checks++; if (err_flags !== 3'b100) begin errors++; $display("FAIL wd_err got %b exp 100", err_flags); end
        data_req = 1'b0;
        wait_idle(n);
        checks++; if (n !== 16) begin errors++; $display("FAIL wd_gap got %0d exp 16", n); end
        checks++; if (abort_cnt - aborts0 !== 1 || data_ack_cnt !== acks0) begin errors++; $display("FAIL wd_counts got %0d/%0d exp 1/0", abort_cnt - aborts0, data_ack_cnt - acks0); end
    endtask

    task automatic test_reset_mid();
        int n;
        int pulses0;
        data_req = 1'b1;
        data_size = 7'd5;
        cyc();
        cyc();
        data_byte = 8'h11;
        get_tx_packet = 1'b1;
        #1;
        checks++; if (data_pop !== 1'b1) begin errors++; $display("FAIL mid_pop got %b exp 1", data_pop); end
        cyc();
        get_tx_packet = 1'b0;
        pulses0 = hs_ack_cnt + data_ack_cnt + abort_cnt;
        rst = 1'b1;
        data_req = 1'b0;
        cyc();
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || tx_packet !== 2'b00) begin errors++; $display("FAIL mid_rst got busy=%b %b exp busy=0 00", busy, tx_packet); end
        checks++; if (tx_packet_data_size !== 7'd0 || err_flags !== 3'b000) begin errors++; $display("FAIL mid_rst_regs got %0d %b exp 0 000", tx_packet_data_size, err_flags); end
        repeat (3) cyc();
        checks++; if (hs_ack_cnt + data_ack_cnt + abort_cnt !== pulses0) begin errors++; $display("FAIL mid_no_pulse got %0d exp %0d", hs_ack_cnt + data_ack_cnt + abort_cnt, pulses0); end
        data_req = 1'b1;
        data_size = 7'd1;
        cyc();
        checks++; if (tx_packet !== 2'b01 || tx_packet_data_size !== 7'd1) begin errors++; $display("FAIL mid_relaunch got %b %0d exp 01 1", tx_packet, tx_packet_data_size); end
        cyc();
        data_byte = 8'h77;
        get_tx_packet = 1'b1;
        #1;
        checks++; if (data_pop !== 1'b1 || tx_packet_data !== 8'h77) begin errors++; $display("FAIL mid_byte got pop=%b %h exp pop=1 77", data_pop, tx_packet_data); end
        cyc();
        get_tx_packet = 1'b0;
        tx_done = 1'b1;
        cyc();
        tx_done = 1'b0;
        data_req = 1'b0;
        checks++; if (data_ack !== 1'b1 || err_flags !== 3'b000) begin errors++; $display("FAIL mid_done got ack=%b %b exp ack=1 000", data_ack, err_flags); end
        wait_idle(n);
    endtask

    initial begin
        rst = 1'b1;
        hs_req = 1'b0;
        hs_type = 1'b0;
        data_req = 1'b0;
        data_size = 7'd0;
        data_byte = 8'h00;
        get_tx_packet = 1'b0;
        tx_done = 1'b0;
        err_clr = 1'b0;
        test_reset();
        test_nak();
        test_data_stream();
        test_priority();
        test_errors();
        test_oversize();
        test_clear_vs_set();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end

endmodule
